restoring_divider: RTL and testbench

//   Sequential unsigned restoring divider for the 20-bit arithmetic unit.

---
 rtl/restoring_divider.sv | 111 +++++++++++
 tb/tb_restoring_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential unsigned restoring divider for the 20-bit arithmetic unit.
//   One trial subtraction per clock; quotient and remainder are available
//   WIDTH cycles after a request is accepted. A zero divisor completes on the
//   accept edge with an all-ones quotient and the dividend as the remainder.
//
// Ports
//   clk          single clock, all state changes on posedge
//   rst_n        synchronous active-low reset
//   start        request; operands sampled on the accepting edge
//   dividend     unsigned dividend (WIDTH bits)
//   divisor      unsigned divisor (WIDTH bits)
//   busy         high while iterating (CALC)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  set together with done when the divisor was zero
module restoring_divider #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   acc;      // partial remainder A, one guard bit
  logic [WIDTH-1:0] q_sh;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs;      // latched divisor
  logic [CW-1:0]    count;

  // Trial subtraction step; the extra top bit of diff is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    shifted  = {acc[WIDTH-1:0], q_sh[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs};
    borrow   = diff[WIDTH+1];
    acc_next = borrow ? shifted : diff[WIDTH:0];
    q_next   = {q_sh[WIDTH-2:0], ~borrow};
  end

  // busy and done are pure decodes of the registered state, so they are
  // glitch-free and follow state transitions exactly.
  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      q_sh        <= '0;
      dvs         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              acc   <= '0;
              q_sh  <= dividend;
              dvs   <= divisor;
              count <= CW'(WIDTH);
              state <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= acc_next;
          q_sh  <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= acc_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
//   Directed-vector bench for restoring_divider with hand-computed results.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_restoring_divider;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge right
  // after the accepting rising edge.
  task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit hold);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Called at a falling edge after an accept. exp_lat is the number of
  // further falling edges until done is seen; busy must be high on exactly
  // that many of the samples.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input bit chk_pulse);
    int lat = 0;
    int busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_q"}, {12'd0, quotient}, {12'd0, eq});
    check({tag, "_r"}, {12'd0, remainder}, {12'd0, er});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    if (chk_pulse) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_q_hold"}, {12'd0, quotient}, {12'd0, eq});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {12'd0, quotient}, 32'd0);
    check("rst_r", {12'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. basic
    do_div(20'd100, 20'd7, 1'b0);
    wait_result("t1_100_7", W, 20'd14, 20'd2, 1'b0, 1'b1);

    // 2. extremes
    do_div(20'hFFFFF, 20'h00001, 1'b0);
    wait_result("t2_max_1", W, 20'hFFFFF, 20'd0, 1'b0, 1'b1);
    do_div(20'hAAAAA, 20'h55555, 1'b0);
    wait_result("t2_a_5", W, 20'd2, 20'd0, 1'b0, 1'b1);

    // 3. small quotient
    do_div(20'd3, 20'h7FFFF, 1'b0);
    wait_result("t3_3_7ffff", W, 20'd0, 20'd3, 1'b0, 1'b1);
    do_div(20'd0, 20'h12345, 1'b0);
    wait_result("t3_0_12345", W, 20'd0, 20'd0, 1'b0, 1'b1);

    // 4. divide by zero: done already visible after the accept edge
    do_div(20'd5, 20'd0, 1'b0);
    wait_result("t4_dbz", 0, 20'hFFFFF, 20'd5, 1'b1, 1'b1);

    // 5a. start during CALC is ignored; operands change after accept
    do_div(20'd100, 20'd7, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 20'd50;
    divisor  = 20'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 20'd0;
    divisor  = 20'd0;
    wait_result("t5_ignore", W - 4, 20'd14, 20'd2, 1'b0, 1'b1);

    // 5b. reset in the middle of CALC
    do_div(20'd1000, 20'd9, 1'b0);
    repeat (9) @(negedge clk);
    check("t5_mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_q", {12'd0, quotient}, 32'd0);
    check("t5_rst_r", {12'd0, remainder}, 32'd0);
    check("t5_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    do_div(20'd9, 20'd3, 1'b0);
    wait_result("t5_9_3", W, 20'd3, 20'd0, 1'b0, 1'b1);

    // 6. start held high through DONE: back-to-back accept
    do_div(20'd12, 20'd4, 1'b1);
    wait_result("t6_first", W - 0, 20'd3, 20'd0, 1'b0, 1'b0);
    dividend = 20'd50;
    divisor  = 20'd6;
    @(negedge clk);
    start = 1'b0;
    check("t6_b2b_busy", {31'd0, busy}, 32'd1);
    check("t6_b2b_done", {31'd0, done}, 32'd0);
    check("t6_b2b_q_hold", {12'd0, quotient}, 32'd3);
    check("t6_b2b_r_hold", {12'd0, remainder}, 32'd0);
    wait_result("t6_second", W, 20'd8, 20'd2, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
